// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter that owns the select/enable of a shared 2-to-4 decoder.
// Four requesters, registered select/enable, hold-limit timeout with a TOUT pulse.

module decoder_rr_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic [1:0] A,
    output logic       E,
    output logic [3:0] GNT,
    output logic       BUSY,
    output logic       TOUT
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       a_q, a_d;
    logic             e_q, e_d;
    logic             tout_q, tout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       rel_done;
    logic       rel_drop;
    logic       rel_expire;
    logic       release_now;

    // Rotating priority search: first set request at ptr, ptr+1, ptr+2, ptr+3.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && REQ[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        rel_done    = DONE;
        rel_drop    = !REQ[a_q];
        rel_expire  = (cnt_q == HOLD_LAST);
        release_now = rel_done || rel_drop || rel_expire;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        e_d     = e_q;
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                e_d = 1'b0;
                if (win_found) begin
                    a_d     = win_idx;
                    e_d     = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (release_now) begin
                    e_d     = 1'b0;
                    ptr_d   = a_q + 2'd1;
                    state_d = IDLE;
                    // A timeout is only flagged when nothing else would have released.
                    tout_d  = rel_expire && !rel_done && !rel_drop;
                end
            end
            default: begin
                state_d = IDLE;
                e_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            a_q     <= 2'd0;
            e_q     <= 1'b0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            e_q     <= e_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    // Grant is decoded from flops only, so it cannot glitch on request changes.
    assign A    = a_q;
    assign E    = e_q;
    assign GNT  = e_q ? (4'b0001 << a_q) : 4'b0000;
    assign BUSY = e_q;
    assign TOUT = tout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter (HOLD_MAX=4): vector table fed through an
// expected-value queue, plus reset and mid-grant asynchronous reset sequences.

module tb_decoder_rr_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] REQ;
    logic       DONE;
    logic [1:0] A;
    logic       E;
    logic [3:0] GNT;
    logic       BUSY;
    logic       TOUT;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [1:0] a;
        logic       e;
        logic [3:0] gnt;
        logic       tout;
    } vec_t;

    typedef struct {
        logic [1:0] a;
        logic       e;
        logic [3:0] gnt;
        logic       tout;
        int         tag;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[27];

    decoder_rr_arbiter #(.HOLD_MAX(4), .CNT_W(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ  (REQ),
        .DONE (DONE),
        .A    (A),
        .E    (E),
        .GNT  (GNT),
        .BUSY (BUSY),
        .TOUT (TOUT)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string nm, input int tag, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("[TB] FAIL %s #%0d: got %0d want %0d", nm, tag, act, want);
        end
    endtask

    task automatic check_now(input string nm, input logic [1:0] a, input logic e,
                             input logic [3:0] gnt, input logic tout);
        cmp({nm, ".A"}, 0, int'(A), int'(a));
        cmp({nm, ".E"}, 0, int'(E), int'(e));
        cmp({nm, ".GNT"}, 0, int'(GNT), int'(gnt));
        cmp({nm, ".BUSY"}, 0, int'(BUSY), int'(e));
        cmp({nm, ".TOUT"}, 0, int'(TOUT), int'(tout));
    endtask

    task automatic check_output();
        exp_t x;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard: got empty queue want one entry");
        end else begin
            total--;
            x = sb.pop_front();
            cmp("A", x.tag, int'(A), int'(x.a));
            cmp("E", x.tag, int'(E), int'(x.e));
            cmp("GNT", x.tag, int'(GNT), int'(x.gnt));
            cmp("BUSY", x.tag, int'(BUSY), int'(x.e));
            cmp("TOUT", x.tag, int'(TOUT), int'(x.tout));
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] req, input logic done, input vec_t v,
                                  input int tag);
        exp_t x;
        @(negedge CLK);
        REQ  = req;
        DONE = done;
        x.a = v.a; x.e = v.e; x.gnt = v.gnt; x.tout = v.tout; x.tag = tag;
        sb.push_back(x);
        @(posedge CLK);
        #1;
        check_output();
    endtask

    initial begin
        #100000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        vec_t v;
        //            req      done  a     e     gnt      tout
        vecs[0]  = '{4'b0101, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0};
        vecs[1]  = '{4'b0101, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0};
        vecs[2]  = '{4'b0101, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0};
        vecs[3]  = '{4'b0101, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0};
        vecs[4]  = '{4'b1001, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b0};
        vecs[5]  = '{4'b1001, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0};
        vecs[6]  = '{4'b1001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0};
        vecs[7]  = '{4'b1001, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0};
        vecs[8]  = '{4'b1001, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b0};
        vecs[9]  = '{4'b1001, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0};
        vecs[10] = '{4'b1001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0};
        vecs[11] = '{4'b1001, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0};
        vecs[12] = '{4'b0010, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b0};
        vecs[13] = '{4'b0010, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b0};
        vecs[14] = '{4'b0010, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b0};
        vecs[15] = '{4'b0010, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b0};
        vecs[16] = '{4'b0010, 1'b0, 2'd1, 1'b0, 4'b0000, 1'b1};
        vecs[17] = '{4'b0010, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b0};
        vecs[18] = '{4'b1011, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b0};
        vecs[19] = '{4'b1101, 1'b0, 2'd1, 1'b0, 4'b0000, 1'b0};
        vecs[20] = '{4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0};
        vecs[21] = '{4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0};
        vecs[22] = '{4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0};
        vecs[23] = '{4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0};
        vecs[24] = '{4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0};
        vecs[25] = '{4'b0100, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0};
        vecs[26] = '{4'b0000, 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0};

        RST  = 1'b1;
        REQ  = 4'b1111;
        DONE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_now("reset", 2'd0, 1'b0, 4'b0000, 1'b0);
        end
        @(negedge CLK);
        RST = 1'b0;
        REQ = 4'b0000;

        for (int i = 0; i < 27; i++) begin
            apply_stimulus(vecs[i].req, vecs[i].done, vecs[i], i);
        end

        // Grant requester 3, then hit reset between clock edges.
        v = '{4'b1000, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b0};
        apply_stimulus(4'b1000, 1'b0, v, 100);
        #2;
        RST = 1'b1;
        REQ = 4'b1111;
        #1;
        check_now("async_rst", 2'd0, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check_now("rst_hold", 2'd0, 1'b0, 4'b0000, 1'b0);
        end
        @(negedge CLK);
        RST = 1'b0;
        REQ = 4'b0000;

        v = '{4'b1010, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b0};
        apply_stimulus(4'b1010, 1'b0, v, 101);
        v = '{4'b1010, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0};
        apply_stimulus(4'b1010, 1'b1, v, 102);
        v = '{4'b1010, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b0};
        apply_stimulus(4'b1010, 1'b0, v, 103);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Round-robin arbiter that shares the team's 2-to-4 decoder (select `A`, enable `E`, one-hot output `O`) between four requesters. It selects one requester at a time, drives the decoder select and enable from registers, and holds each grant until the owner releases it or a hold limit expires. It sits directly in front of the decoder instance. It also emits the decoded one-hot grant itself, so downstream logic does not depend on decoder combinational delay.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive grant cycles per owner; legal range 1..2^`CNT_W`-1.
- `CNT_W`, default 4: width of the hold counter.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `REQ` input 4: request vector; bit i high means requester i wants the decoder.
- `DONE` input 1: owner release strobe, sampled only while granting.
- `A` output 2: decoder select (registered); index of the current or last owner.
- `E` output 1: decoder enable (registered); high exactly while a grant is active.
- `GNT` output 4: one-hot grant, equal to `E ? (4'b0001 << A) : 4'b0000`.
- `BUSY` output 1: equals `E`.
- `TOUT` output 1: one-cycle pulse, registered, marking a release forced by `HOLD_MAX`.

## Operation
- Internal state:
  - FSM states IDLE and GRANT.
  - Round-robin pointer `PTR[1:0]`.
  - Hold counter `CNT[CNT_W-1:0]`.
- Reset values: state IDLE, `PTR`=0, `CNT`=0, `A`=2'b00, `E`=0, `GNT`=4'b0000, `BUSY`=0, `TOUT`=0.
- IDLE:
  - `E`=0.
  - If `REQ`≠0, pick the first set bit searching `PTR`, `PTR`+1, `PTR`+2, `PTR`+3 (mod 4).
  - Then `A`←winner, `E`←1, `CNT`←0, go to GRANT.
  - If `REQ`=0, stay in IDLE; `A` holds its value.
- GRANT:
  - Each cycle, `CNT`←`CNT`+1.
  - Release when any of the following holds at the edge:
    - (a) `DONE`=1;
    - (b) `REQ[A]`=0;
    - (c) `CNT`==`HOLD_MAX`-1.
  - On release: `E`←0, `PTR`←`A`+1 (3 wraps to 0), go to IDLE.
  - `TOUT`←1 only if (c) holds while (a) and (b) do not.
- Every grant passes through at least one IDLE cycle. A new winner is never granted on the same edge that releases the old one.
- `REQ` bits other than `REQ[A]` are ignored during GRANT. Requests that drop before being granted are never granted.
- `A` never changes while `E`=1.
- `GNT` is combinational from registered `A`/`E`, so it is glitch-free across state changes.
- `TOUT` is cleared on every edge where it is not being set.

## Timing
- Request to grant: `REQ` is sampled at edge k; `E`/`GNT` are high after edge k. This is 1 cycle of latency from IDLE.
- Release: `DONE` sampled at edge k drops `E` after edge k. The next grant is earliest after edge k+1.
- Maximum grant length is `HOLD_MAX` cycles. `TOUT` is high during the first IDLE cycle after a forced release.
- Simultaneous `DONE` and hold expiry: treated as a normal release, `TOUT`=0.
- `HOLD_MAX`=1: every grant lasts exactly one cycle and `TOUT` pulses unless `DONE` or a dropped `REQ` coincides.
- `RST` asserted mid-grant: all outputs go to reset values immediately, without waiting for a clock edge. After release of `RST`, arbitration restarts at requester 0.
- Worst-case wait for a continuously requesting input is 3×(`HOLD_MAX`+1) cycles.

## Test plan
- Reset check: assert `RST` with `REQ`=4'b1111 → `A`=00, `E`=0, `GNT`=0000, `TOUT`=0, held for the full reset duration.
- Basic grant and release: after reset, apply `REQ`=4'b0101 → `GNT`=0001 one cycle later. Pulse `DONE` → one cycle `GNT`=0000, then `GNT`=0100 (`A`=10).
- Round-robin wrap: keep `REQ`=4'b1001 and pulse `DONE` on each grant → grant order 0, 3, 0, 3, with `PTR` wrapping 3→0.
- Hold timeout with `HOLD_MAX`=4: hold `REQ`=4'b0010 with `DONE`=0 → `GNT`=0010 for exactly 4 cycles, then `TOUT` pulses for 1 cycle with `GNT`=0000, then `GNT`=0010 again.
- Request drop and coincidence:
  - Drop `REQ[A]` mid-grant → release next edge with `TOUT`=0.
  - Assert `DONE` on the expiry cycle → release with `TOUT`=0.
- Asynchronous reset mid-grant: during `GNT`=1000, assert `RST` between clock edges → `E`=0 and `GNT`=0000 before the next edge. After reset, `REQ`=4'b1010 → `GNT`=0010 first.
